// File: rtl/asg_out_pkg.sv
// Shared types and default widths for the ASG output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package asg_out_pkg;

  localparam int ASG_DW    = 14;
  localparam int ASG_CNT_W = 32;

  // Output-stage mode: normal tracking, ramping to 0, parked at 0, ramping back.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUTING   = 2'd1,
    MUTED    = 2'd2,
    UNMUTING = 2'd3
  } asg_state_e;

endpackage

// File: rtl/asg_slew_step.sv
// Moves cur toward target by at most step; step of 0 means jump straight to target.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module asg_slew_step
  import asg_out_pkg::*;
#(
  parameter int DW = ASG_DW
) (
  input  logic signed [DW-1:0] cur,
  input  logic signed [DW-1:0] target,
  input  logic        [DW-1:0] step,
  output logic signed [DW-1:0] nxt,
  output logic                 clipped
);

  logic [DW:0] diff;
  logic [DW:0] mag;
  logic [DW:0] sum_up;
  logic [DW:0] sum_dn;

  // One extra bit keeps the full-scale difference (+/-(2^DW-1)) exact.
  always_comb begin
    diff    = {target[DW-1], target} - {cur[DW-1], cur};
    mag     = diff[DW] ? (~diff + 1'b1) : diff;
    clipped = (step != '0) && (mag > {1'b0, step});
    sum_up  = {cur[DW-1], cur} + {1'b0, step};
    sum_dn  = {cur[DW-1], cur} - {1'b0, step};
    // A clipped result lies strictly between cur and target, so truncation is safe.
    if (!clipped)
      nxt = target;
    else if (diff[DW])
      nxt = sum_dn[DW-1:0];
    else
      nxt = sum_up[DW-1:0];
  end

endmodule

// File: rtl/asg_out_slew_limiter.sv
// ASG channel output slew limiter with soft mute, status flags and clipped-cycle counter.
// Latency: 1 cycle asg_dat_i -> dac_o when not limiting.
// Backpressure: none; a new sample is accepted every dac_clk_i cycle.
module asg_out_slew_limiter
  import asg_out_pkg::*;
#(
  parameter int DW    = ASG_DW,
  parameter int CNT_W = ASG_CNT_W
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rst_i,
  input  logic signed [DW-1:0] asg_dat_i,
  input  logic        [DW-1:0] set_step_i,
  input  logic                 set_mute_i,
  input  logic                 cnt_clr_i,
  output logic signed [DW-1:0] dac_o,
  output logic                 limiting_o,
  output logic                 muted_o,
  output logic                 busy_o,
  output logic     [CNT_W-1:0] lim_cnt_o
);

  asg_state_e          state_q;
  asg_state_e          state_d;
  logic signed [DW-1:0] dac_q;
  logic                 lim_q;
  logic     [CNT_W-1:0] cnt_q;
  logic signed [DW-1:0] target;
  logic signed [DW-1:0] dac_d;
  logic                 clipped;

  // Mute ramps head for 0; otherwise follow the channel sample.
  always_comb begin
    target = asg_dat_i;
    if (state_q == MUTING || state_q == MUTED)
      target = '0;
  end

  asg_slew_step #(.DW(DW)) u_step (
    .cur     (dac_q),
    .target  (target),
    .step    (set_step_i),
    .nxt     (dac_d),
    .clipped (clipped)
  );

  // Next-state decisions look at this cycle's computed output, not the registered one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (set_mute_i) state_d = MUTING;
      MUTING:   if (!set_mute_i) state_d = UNMUTING;
                else if (dac_d == '0) state_d = MUTED;
      MUTED:    if (!set_mute_i) state_d = UNMUTING;
      UNMUTING: if (set_mute_i) state_d = MUTING;
                else if (!clipped) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Output, flag, state and counter registers; counter clear beats increment and sticks at all-ones.
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= RUN;
      dac_q   <= '0;
      lim_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      lim_q   <= clipped;
      if (cnt_clr_i)
        cnt_q <= '0;
      else if (state_q == RUN && clipped && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dac_o      = dac_q;
  assign limiting_o = lim_q;
  assign muted_o    = (state_q == MUTED);
  assign busy_o     = (state_q == MUTING) || (state_q == UNMUTING);
  assign lim_cnt_o  = cnt_q;

endmodule

// File: tb/tb_asg_out_slew_limiter.sv
// Randomized + directed bench for asg_out_slew_limiter against an arithmetic reference model.
// Latency: model predicts registered outputs one edge after inputs are applied.
// Backpressure: n/a.
module tb_asg_out_slew_limiter;

  localparam int DW     = 14;
  localparam int CNT_W  = 8;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic                 dac_clk_i = 1'b0;
  logic                 dac_rst_i;
  logic signed [DW-1:0] asg_dat_i;
  logic        [DW-1:0] set_step_i;
  logic                 set_mute_i;
  logic                 cnt_clr_i;
  logic signed [DW-1:0] dac_o;
  logic                 limiting_o;
  logic                 muted_o;
  logic                 busy_o;
  logic     [CNT_W-1:0] lim_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 tracking, 1 ramping to zero, 2 parked at zero, 3 ramping back.
  int m_dac;
  int m_lim;
  int m_cnt;
  int m_mode;

  asg_out_slew_limiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .dac_clk_i  (dac_clk_i),
    .dac_rst_i  (dac_rst_i),
    .asg_dat_i  (asg_dat_i),
    .set_step_i (set_step_i),
    .set_mute_i (set_mute_i),
    .cnt_clr_i  (cnt_clr_i),
    .dac_o      (dac_o),
    .limiting_o (limiting_o),
    .muted_o    (muted_o),
    .busy_o     (busy_o),
    .lim_cnt_o  (lim_cnt_o)
  );

  always #5 dac_clk_i = ~dac_clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, update the model from the pre-edge state, compare every output.
  task automatic cyc();
    int tgt, diff, mag, stp, nd, cl, nm;
    stp = int'(set_step_i);
    tgt = (m_mode == 1 || m_mode == 2) ? 0 : int'(asg_dat_i);
    diff = tgt - m_dac;
    mag = (diff < 0) ? -diff : diff;
    if (stp == 0 || mag <= stp) begin
      nd = tgt; cl = 0;
    end else begin
      nd = (diff > 0) ? m_dac + stp : m_dac - stp; cl = 1;
    end
    nm = m_mode;
    case (m_mode)
      0: if (set_mute_i) nm = 1;
      1: if (!set_mute_i) nm = 3; else if (nd == 0) nm = 2;
      2: if (!set_mute_i) nm = 3;
      default: if (set_mute_i) nm = 1; else if (cl == 0) nm = 0;
    endcase
    @(posedge dac_clk_i);
    if (dac_rst_i) begin
      m_dac = 0; m_lim = 0; m_cnt = 0; m_mode = 0;
    end else begin
      if (cnt_clr_i) m_cnt = 0;
      else if (m_mode == 0 && cl == 1 && m_cnt < CNT_MX) m_cnt++;
      m_dac = nd; m_lim = cl; m_mode = nm;
    end
    #1;
    check("dac_o", int'(dac_o), m_dac);
    check("limiting_o", int'(limiting_o), m_lim);
    check("muted_o", int'(muted_o), (m_mode == 2) ? 1 : 0);
    check("busy_o", int'(busy_o), (m_mode == 1 || m_mode == 3) ? 1 : 0);
    check("lim_cnt_o", int'(lim_cnt_o), m_cnt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Run until the model reaches a given mode/output pair; an expired budget is a failure.
  task automatic run_until(input string tag, input int mode, input int val, input int budget);
    int k;
    k = 0;
    while (!(m_mode == mode && m_dac == val) && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_reached"}, (m_mode == mode && m_dac == val) ? 1 : 0, 1);
  endtask

  initial begin
    m_dac = 0; m_lim = 0; m_cnt = 0; m_mode = 0;
    dac_rst_i = 1'b1; asg_dat_i = '0; set_step_i = '0; set_mute_i = 1'b0; cnt_clr_i = 1'b0;
    run(2);
    dac_rst_i = 1'b0;

    // Slew up from 0 in steps of 100.
    set_step_i = 14'd100; asg_dat_i = 14'sd1000;
    run(12);
    check("ramp_cnt", int'(lim_cnt_o), 9);

    // Bypass with full-scale toggling.
    set_step_i = '0;
    for (int i = 0; i < 8; i++) begin
      asg_dat_i = (i % 2 == 0) ? -14'sd8192 : 14'sd8191;
      cyc();
    end

    // Settle at 5000 and mute with step 1000.
    asg_dat_i = 14'sd5000; set_step_i = 14'd1000;
    run(20);
    set_mute_i = 1'b1;
    run(9);
    check("muted_hold", int'(dac_o), 0);

    // Release mid-ramp at 2000.
    set_mute_i = 1'b0;
    run(8);
    set_mute_i = 1'b1;
    run_until("mute_2000", 1, 2000, 10);
    set_mute_i = 1'b0;
    run(6);

    // Mute when already at zero: one cycle of MUTING then MUTED.
    asg_dat_i = '0; set_step_i = '0;
    run(2);
    set_mute_i = 1'b1;
    run(3);
    set_mute_i = 1'b0;
    run(2);

    // Force clipping every cycle to saturate the counter, then clear on a clipped cycle.
    set_step_i = 14'd1;
    for (int i = 0; i < CNT_MX + 20; i++) begin
      asg_dat_i = (i % 2 == 0) ? 14'sd8000 : -14'sd8000;
      cyc();
    end
    check("cnt_sat", int'(lim_cnt_o), CNT_MX);
    cnt_clr_i = 1'b1;
    cyc();
    cnt_clr_i = 1'b0;
    check("cnt_clr", int'(lim_cnt_o), 0);

    // Reset in the middle of an unmute ramp toward -5000.
    asg_dat_i = -14'sd5000; set_step_i = 14'd1000;
    run(20);
    set_mute_i = 1'b1;
    run(8);
    set_mute_i = 1'b0;
    run_until("unmute_m3000", 3, -3000, 10);
    dac_rst_i = 1'b1;
    cyc();
    dac_rst_i = 1'b0;
    check("rst_busy", int'(busy_o), 0);

    // Randomized traffic with occasional reset, clear and mute toggling.
    for (int i = 0; i < 3000; i++) begin
      asg_dat_i = DW'($urandom_range(0, (1 << DW) - 1));
      case ($urandom_range(0, 5))
        0: set_step_i = '0;
        1: set_step_i = 14'h3fff;
        2: set_step_i = DW'($urandom_range(1, 16));
        default: set_step_i = DW'($urandom_range(1, 3000));
      endcase
      if ($urandom_range(0, 20) == 0) set_mute_i = ~set_mute_i;
      cnt_clr_i = ($urandom_range(0, 60) == 0);
      dac_rst_i = ($urandom_range(0, 200) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
